alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_pkg.sv | 51 +++++
 rtl/alu_arbiter_if.sv | 37 +++
 rtl/alu.sv | 28 ++
 rtl/alu_arbiter.sv | 79 +++++++
 tb/tb_alu_arbiter.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the two-port ALU arbiter.
package alu_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned OP_W    = 4;
    localparam int unsigned SHAMT_W = 5;

    localparam logic [OP_W-1:0] OP_ADD  = 4'b0000;
    localparam logic [OP_W-1:0] OP_SUB  = 4'b1000;
    localparam logic [OP_W-1:0] OP_SLT  = 4'b0010;
    localparam logic [OP_W-1:0] OP_SLTU = 4'b0011;
    localparam logic [OP_W-1:0] OP_XOR  = 4'b0100;
    localparam logic [OP_W-1:0] OP_OR   = 4'b0110;
    localparam logic [OP_W-1:0] OP_AND  = 4'b0111;
    localparam logic [OP_W-1:0] OP_SLL  = 4'b0001;
    localparam logic [OP_W-1:0] OP_SRL  = 4'b0101;
    localparam logic [OP_W-1:0] OP_SRA  = 4'b1101;

    typedef enum logic [OP_W-1:0] {
        ALU_ADD  = OP_ADD,
        ALU_SUB  = OP_SUB,
        ALU_SLT  = OP_SLT,
        ALU_SLTU = OP_SLTU,
        ALU_XOR  = OP_XOR,
        ALU_OR   = OP_OR,
        ALU_AND  = OP_AND,
        ALU_SLL  = OP_SLL,
        ALU_SRL  = OP_SRL,
        ALU_SRA  = OP_SRA
    } alu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FULL = 1'b1
    } state_e;

    typedef logic owner_t;
    localparam owner_t OWNER_0 = 1'b0;
    localparam owner_t OWNER_1 = 1'b1;

    typedef struct packed {
        logic [OP_W-1:0] op;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
    } alu_req_t;

    function automatic logic is_shift(input logic [OP_W-1:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle for both requesters of the shared ALU.
interface alu_arbiter_if;
    import alu_pkg::*;

    logic            req0_valid_i;
    logic            req0_ready_o;
    logic [OP_W-1:0] req0_op_i;
    logic [XLEN-1:0] req0_a_i;
    logic [XLEN-1:0] req0_b_i;
    logic            rsp0_valid_o;
    logic            rsp0_ready_i;
    logic [XLEN-1:0] rsp0_data_o;

    logic            req1_valid_i;
    logic            req1_ready_o;
    logic [OP_W-1:0] req1_op_i;
    logic [XLEN-1:0] req1_a_i;
    logic [XLEN-1:0] req1_b_i;
    logic            rsp1_valid_o;
    logic            rsp1_ready_i;
    logic [XLEN-1:0] rsp1_data_o;

    modport master (
        output req0_valid_i, req0_op_i, req0_a_i, req0_b_i, rsp0_ready_i,
        output req1_valid_i, req1_op_i, req1_a_i, req1_b_i, rsp1_ready_i,
        input  req0_ready_o, rsp0_valid_o, rsp0_data_o,
        input  req1_ready_o, rsp1_valid_o, rsp1_data_o
    );

    modport slave (
        input  req0_valid_i, req0_op_i, req0_a_i, req0_b_i, rsp0_ready_i,
        input  req1_valid_i, req1_op_i, req1_a_i, req1_b_i, rsp1_ready_i,
        output req0_ready_o, rsp0_valid_o, rsp0_data_o,
        output req1_ready_o, rsp1_valid_o, rsp1_data_o
    );

endinterface

// File: rtl/alu.sv
// Combinational 32-bit ALU; unknown opcodes yield zero.
module alu
    import alu_pkg::*;
(
    input  logic [OP_W-1:0] op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result_c
);

    always_comb begin
        result_c = '0;
        case (op)
            ALU_ADD:  result_c = a + b;
            ALU_SUB:  result_c = a - b;
            ALU_SLT:  result_c = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: result_c = {{(XLEN-1){1'b0}}, (a < b)};
            ALU_XOR:  result_c = a ^ b;
            ALU_OR:   result_c = a | b;
            ALU_AND:  result_c = a & b;
            ALU_SLL:  result_c = a << b[SHAMT_W-1:0];
            ALU_SRL:  result_c = a >> b[SHAMT_W-1:0];
            ALU_SRA:  result_c = $unsigned($signed(a) >>> b[SHAMT_W-1:0]);
            default:  result_c = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two requesters share one ALU through a single-entry result slot tagged with its owner.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    alu_arbiter_if.slave bus
);

    state_e          state_q, state_d;
    owner_t          owner_q, last_q, sel_c;
    logic [XLEN-1:0] data_q, b_c, result_c;
    alu_req_t        req_c;
    logic            consume_c, slot_free_c, prio0_c;
    logic            ready0_c, ready1_c, accept_c;
    logic            rsp0_valid_c, rsp1_valid_c;

    // Arbitration and next state; a port's ready looks only at the other port's valid.
    always_comb begin
        state_d     = state_q;
        consume_c   = (state_q == ST_FULL) &&
                      ((owner_q == OWNER_1) ? bus.rsp1_ready_i : bus.rsp0_ready_i);
        slot_free_c = (state_q == ST_IDLE) || consume_c;
        prio0_c     = (FIXED_PRIO != 0) || (last_q == OWNER_1);
        ready0_c    = rst_ni && slot_free_c && (prio0_c || !bus.req1_valid_i);
        ready1_c    = rst_ni && slot_free_c && (!prio0_c || !bus.req0_valid_i);
        sel_c       = (bus.req1_valid_i && ready1_c) ? OWNER_1 : OWNER_0;
        accept_c    = (bus.req0_valid_i && ready0_c) || (bus.req1_valid_i && ready1_c);

        unique case (state_q)
            ST_IDLE: if (accept_c) state_d = ST_FULL;
            ST_FULL: if (!accept_c && consume_c) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand select; shifts only see the low five bits of B.
    always_comb begin
        req_c = {bus.req0_op_i, bus.req0_a_i, bus.req0_b_i};
        if (sel_c == OWNER_1) req_c = {bus.req1_op_i, bus.req1_a_i, bus.req1_b_i};
        b_c = is_shift(req_c.op) ? XLEN'(req_c.b[SHAMT_W-1:0]) : req_c.b;
    end

    alu u_alu (
        .op       (req_c.op),
        .a        (req_c.a),
        .b        (b_c),
        .result_c (result_c)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            owner_q <= OWNER_0;
            last_q  <= OWNER_1;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept_c) begin
                owner_q <= sel_c;
                last_q  <= sel_c;
                data_q  <= result_c;
            end
        end
    end

    assign rsp0_valid_c = (state_q == ST_FULL) && (owner_q == OWNER_0);
    assign rsp1_valid_c = (state_q == ST_FULL) && (owner_q == OWNER_1);

    assign bus.req0_ready_o = ready0_c;
    assign bus.req1_ready_o = ready1_c;
    assign bus.rsp0_valid_o = rsp0_valid_c;
    assign bus.rsp1_valid_o = rsp1_valid_c;
    assign bus.rsp0_data_o  = rsp0_valid_c ? data_q : '0;
    assign bus.rsp1_data_o  = rsp1_valid_c ? data_q : '0;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed checks of the shared-ALU arbiter in round-robin and fixed-priority builds.
module tb_alu_arbiter;
    import alu_pkg::*;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    int unsigned passed = 0;
    int unsigned failed = 0;
    int unsigned total  = 0;

    localparam int unsigned NV = 8;
    localparam logic [3:0]  V_OP  [NV] = '{4'b1101, 4'b1111, 4'b0010, 4'b0011,
                                            4'b0001, 4'b0101, 4'b0111, 4'b0100};
    localparam logic [31:0] V_A   [NV] = '{32'h80000000, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                            32'd1, 32'h80000000, 32'hF0F0F0F0, 32'hFFFF0000};
    localparam logic [31:0] V_B   [NV] = '{32'd33, 32'd7, 32'd1, 32'd1,
                                            32'd36, 32'd31, 32'hFF00FF00, 32'h0F0F0F0F};
    localparam logic [31:0] V_EXP [NV] = '{32'hC0000000, 32'h0, 32'h1, 32'h0,
                                            32'h10, 32'h1, 32'hF000F000, 32'hF0F00F0F};

    alu_arbiter_if bus_r ();
    alu_arbiter_if bus_f ();

    alu_arbiter #(.FIXED_PRIO(0)) dut_rr (.clk_i(clk_i), .rst_ni(rst_ni), .bus(bus_r));
    alu_arbiter #(.FIXED_PRIO(1)) dut_fp (.clk_i(clk_i), .rst_ni(rst_ni), .bus(bus_f));

    always #5 clk_i = ~clk_i;

    task automatic check1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        bus_r.req0_valid_i = 1'b0; bus_r.req0_op_i = 4'd0; bus_r.req0_a_i = '0; bus_r.req0_b_i = '0;
        bus_r.req1_valid_i = 1'b0; bus_r.req1_op_i = 4'd0; bus_r.req1_a_i = '0; bus_r.req1_b_i = '0;
        bus_r.rsp0_ready_i = 1'b1; bus_r.rsp1_ready_i = 1'b1;
        bus_f.req0_valid_i = 1'b0; bus_f.req0_op_i = 4'd0; bus_f.req0_a_i = '0; bus_f.req0_b_i = '0;
        bus_f.req1_valid_i = 1'b0; bus_f.req1_op_i = 4'd0; bus_f.req1_a_i = '0; bus_f.req1_b_i = '0;
        bus_f.rsp0_ready_i = 1'b1; bus_f.rsp1_ready_i = 1'b1;

        // reset state
        #1;
        check1("rst rsp0_valid", bus_r.rsp0_valid_o, 1'b0);
        check1("rst rsp1_valid", bus_r.rsp1_valid_o, 1'b0);
        check32("rst rsp0_data", bus_r.rsp0_data_o, 32'h0);
        check1("rst req0_ready", bus_r.req0_ready_o, 1'b0);
        check1("rst req1_ready", bus_r.req1_ready_o, 1'b0);
        tick(); tick();
        rst_ni = 1'b1;
        tick();

        // single request: ADD 5+7
        bus_r.req0_valid_i = 1'b1; bus_r.req0_op_i = 4'b0000;
        bus_r.req0_a_i = 32'd5; bus_r.req0_b_i = 32'd7;
        #1;
        check1("single req0_ready", bus_r.req0_ready_o, 1'b1);
        tick();
        bus_r.req0_valid_i = 1'b0;
        check1("single rsp0_valid", bus_r.rsp0_valid_o, 1'b1);
        check32("single rsp0_data", bus_r.rsp0_data_o, 32'd12);
        check1("single rsp1_valid", bus_r.rsp1_valid_o, 1'b0);
        tick();
        check1("single drained", bus_r.rsp0_valid_o, 1'b0);
        check32("single data zero", bus_r.rsp0_data_o, 32'h0);

        // round-robin: port 0 granted last, so port 1 leads
        bus_r.req0_valid_i = 1'b1; bus_r.req0_op_i = 4'b0100;
        bus_r.req0_a_i = 32'h0000FF00; bus_r.req0_b_i = 32'h00000F0F;
        bus_r.req1_valid_i = 1'b1; bus_r.req1_op_i = 4'b0110;
        bus_r.req1_a_i = 32'h000000F0; bus_r.req1_b_i = 32'h0000000F;
        #1;
        check1("rr first ready0", bus_r.req0_ready_o, 1'b0);
        check1("rr first ready1", bus_r.req1_ready_o, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 3) begin
                bus_r.req0_valid_i = 1'b0;
                bus_r.req1_valid_i = 1'b0;
            end
            check1($sformatf("rr%0d rsp1_valid", i), bus_r.rsp1_valid_o, (i % 2) == 0);
            check1($sformatf("rr%0d rsp0_valid", i), bus_r.rsp0_valid_o, (i % 2) == 1);
            check32($sformatf("rr%0d data", i),
                    (i % 2 == 0) ? bus_r.rsp1_data_o : bus_r.rsp0_data_o,
                    (i % 2 == 0) ? 32'h000000FF : 32'h0000F00F);
        end
        tick();
        check1("rr drained", bus_r.rsp0_valid_o, 1'b0);

        // fixed priority: port 1 starves while port 0 is valid
        bus_f.req0_valid_i = 1'b1; bus_f.req0_op_i = 4'b0000;
        bus_f.req0_a_i = 32'd5; bus_f.req0_b_i = 32'd7;
        bus_f.req1_valid_i = 1'b1; bus_f.req1_op_i = 4'b0111;
        bus_f.req1_a_i = 32'h0000F0F0; bus_f.req1_b_i = 32'h0000FF00;
        #1;
        check1("fp first ready1", bus_f.req1_ready_o, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check1($sformatf("fp%0d rsp0_valid", i), bus_f.rsp0_valid_o, 1'b1);
            check32($sformatf("fp%0d rsp0_data", i), bus_f.rsp0_data_o, 32'd12);
            check1($sformatf("fp%0d rsp1_valid", i), bus_f.rsp1_valid_o, 1'b0);
            check1($sformatf("fp%0d ready1", i), bus_f.req1_ready_o, 1'b0);
        end
        bus_f.req0_valid_i = 1'b0;
        #1;
        check1("fp ready1 alone", bus_f.req1_ready_o, 1'b1);
        tick();
        bus_f.req1_valid_i = 1'b0;
        check1("fp rsp1_valid", bus_f.rsp1_valid_o, 1'b1);
        check32("fp rsp1_data", bus_f.rsp1_data_o, 32'h0000F000);
        check1("fp rsp0 low", bus_f.rsp0_valid_o, 1'b0);
        tick();
        check1("fp drained", bus_f.rsp1_valid_o, 1'b0);

        // backpressure on port 1 after SUB 3-5
        bus_r.rsp1_ready_i = 1'b0;
        bus_r.req1_valid_i = 1'b1; bus_r.req1_op_i = 4'b1000;
        bus_r.req1_a_i = 32'd3; bus_r.req1_b_i = 32'd5;
        #1;
        check1("bp ready1", bus_r.req1_ready_o, 1'b1);
        tick();
        bus_r.req1_valid_i = 1'b0;
        bus_r.req0_valid_i = 1'b1; bus_r.req0_op_i = 4'b0000;
        bus_r.req0_a_i = 32'd1; bus_r.req0_b_i = 32'd2;
        for (int i = 0; i < 3; i++) begin
            if (i != 0) tick();
            #1;
            check1($sformatf("bp%0d rsp1_valid", i), bus_r.rsp1_valid_o, 1'b1);
            check32($sformatf("bp%0d rsp1_data", i), bus_r.rsp1_data_o, 32'hFFFFFFFE);
            check1($sformatf("bp%0d ready0", i), bus_r.req0_ready_o, 1'b0);
            check1($sformatf("bp%0d ready1", i), bus_r.req1_ready_o, 1'b0);
        end
        bus_r.rsp1_ready_i = 1'b1;
        #1;
        check1("bp release ready0", bus_r.req0_ready_o, 1'b1);
        tick();
        bus_r.req0_valid_i = 1'b0;
        check1("bp next rsp0_valid", bus_r.rsp0_valid_o, 1'b1);
        check32("bp next rsp0_data", bus_r.rsp0_data_o, 32'd3);
        check1("bp rsp1 done", bus_r.rsp1_valid_o, 1'b0);
        tick();
        check1("bp drained", bus_r.rsp0_valid_o, 1'b0);

        // back-to-back opcode table on port 0, incl. shift mask and illegal opcode
        for (int i = 0; i < int'(NV); i++) begin
            bus_r.req0_valid_i = 1'b1; bus_r.req0_op_i = V_OP[i];
            bus_r.req0_a_i = V_A[i]; bus_r.req0_b_i = V_B[i];
            tick();
            check1($sformatf("op%0d rsp0_valid", i), bus_r.rsp0_valid_o, 1'b1);
            check32($sformatf("op%0d rsp0_data", i), bus_r.rsp0_data_o, V_EXP[i]);
        end
        bus_r.req0_valid_i = 1'b0;
        tick();
        check1("ops drained", bus_r.rsp0_valid_o, 1'b0);

        // reset while a port-1 result is held
        bus_r.rsp1_ready_i = 1'b0;
        bus_r.req1_valid_i = 1'b1; bus_r.req1_op_i = 4'b0000;
        bus_r.req1_a_i = 32'd1; bus_r.req1_b_i = 32'd1;
        tick();
        bus_r.req1_valid_i = 1'b0;
        check1("mid held", bus_r.rsp1_valid_o, 1'b1);
        check32("mid held data", bus_r.rsp1_data_o, 32'd2);
        #2;
        rst_ni = 1'b0;
        #1;
        check1("mid rst rsp1_valid", bus_r.rsp1_valid_o, 1'b0);
        check32("mid rst rsp1_data", bus_r.rsp1_data_o, 32'h0);
        check1("mid rst ready0", bus_r.req0_ready_o, 1'b0);
        tick(); tick();
        rst_ni = 1'b1;
        bus_r.rsp1_ready_i = 1'b1;
        tick();
        check1("post rst no stale1", bus_r.rsp1_valid_o, 1'b0);
        check1("post rst no stale0", bus_r.rsp0_valid_o, 1'b0);
        bus_r.req0_valid_i = 1'b1; bus_r.req0_op_i = 4'b0000;
        bus_r.req0_a_i = 32'd5; bus_r.req0_b_i = 32'd7;
        bus_r.req1_valid_i = 1'b1;
        #1;
        check1("post rst tie ready0", bus_r.req0_ready_o, 1'b1);
        check1("post rst tie ready1", bus_r.req1_ready_o, 1'b0);
        tick();
        bus_r.req0_valid_i = 1'b0;
        bus_r.req1_valid_i = 1'b0;
        check1("post rst rsp0_valid", bus_r.rsp0_valid_o, 1'b1);
        check32("post rst rsp0_data", bus_r.rsp0_data_o, 32'd12);
        check1("post rst rsp1_valid", bus_r.rsp1_valid_o, 1'b0);
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
